cdb_writeback_arb: RTL
======================

# cdb_writeback_arb

Writeback arbiter at the consumer end of the execute-stage result registers. Accepts completed results (write-enable, destination register, rename tag, 32-bit data) from the ALU result register and the load-word result register, which can both be valid in the same cycle. Queues the results in a small multi-write FIFO and broadcasts at most one per cycle on the common data bus (CDB), which feeds the reservation stations, the ROB and the register file. Producers have no ready signal, so the block raises an almost-full flag to the issue stage instead.

## Interface
- DEPTH, 4, FIFO entries; power of two, ≥4
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- we_ALU  in  1  ALU result valid
- dst_ALU, tag_ALU  in  5 each  ALU destination register / rename tag
- data_ALU  in  32  ALU result
- we_LW  in  1  load result valid
- dst_LW, tag_LW  in  5 each  load destination register / rename tag
- data_LW  in  32  load data
- cdb_valid  out  1  broadcast valid this cycle
- cdb_dst, cdb_tag  out  5 each  broadcast destination / tag
- cdb_data  out  32  broadcast data
- almost_full  out  1  issue-stage stall request
- ovf_err  out  1  sticky overflow error

## Operation
- Entry fields: {dst, tag, data}, 42 bits. An input is accepted only when its we_* is 1. dst = 0 is still broadcast, because the tag must wake the reservation stations.
- Push: 0, 1 or 2 entries per cycle.
  - If both sources are valid, the LW entry is written at wr_ptr and the ALU entry at wr_ptr+1. Loads are older, so they drain first.
- Pop: exactly one entry per cycle whenever the FIFO is non-empty. There is no CDB backpressure.
- CDB outputs come from the head entry: cdb_valid = (count != 0).
- count_next = count + pushes − pop. Pointers wrap modulo DEPTH. The count width is log2(DEPTH)+1.
- almost_full = (count ≥ DEPTH−2), computed from the registered count. This guarantees room for one more dual push.
- Overflow: any push that finds no free slot after the same-cycle pop is dropped.
  - Order of drops: the ALU entry is dropped first, then the LW entry.
  - ovf_err sets and holds until reset.
  - Accepted entries are never corrupted by a drop.
- Reset (asynchronous, at any time, including mid-drain): pointers and count go to 0 and ovf_err to 0. All queued entries are discarded. FIFO storage is not cleared.

## Timing
- Reset values: cdb_valid=0, cdb_dst=0, cdb_tag=0, cdb_data=0, almost_full=0, ovf_err=0. Outputs are forced to 0 whenever cdb_valid=0.
- Without bypass, a single result valid in cycle n is broadcast in cycle n+1.
- Dual results in cycle n: LW is broadcast in n+1 and ALU in n+2.
- A push and a pop in the same cycle on an empty FIFO never happens without bypass. The head is valid only from the cycle after the write.
- almost_full reflects state after the edge. It rises one cycle after the count crosses the threshold.

## Configuration
- CDB_BYPASS_EN defined: when count = 0 and exactly one source is valid, that result drives the CDB combinationally in the same cycle and is not written to the FIFO (latency 0).
  - If both sources are valid with count = 0, LW is bypassed and ALU is pushed, so ALU is broadcast in n+1.
  - ovf_err and almost_full rules are unchanged.
- Undefined: all results go through the FIFO, with the latency given above.

## Structure
- Package cdb_pkg holds:
  - the cdb_entry_t packed struct {dst[4:0], tag[4:0], data[31:0]}
  - REG_W=5, TAG_W=5, DATA_W=32
  - DEPTH_DEFAULT=4
- Sub-module cdb_fifo: 2-write/1-read FIFO with storage, pointers, count and free-slot computation.
- The top level holds the source ordering, bypass mux, flags and error logic.

## Test plan
- Reset then idle: after rst is released with no inputs, cdb_valid=0 and all outputs are 0 for 10 cycles.
- Single ALU: we_ALU=1, dst=3, tag=7, data=0x0000_00AA in cycle 0 → cdb_valid=1 with dst=3, tag=7, data=0xAA in cycle 1 (cycle 0 with bypass). Then cdb_valid=0.
- Dual push: LW (dst=4, tag=2, data=0xDEAD_BEEF) and ALU (dst=5, tag=9, data=0x1) both in cycle 0 → LW broadcast in cycle 1, ALU in cycle 2.
- Sustained dual push, DEPTH=4: both sources valid in cycles 0–1 → almost_full=1 by cycle 2. Entries drain in order LW0, ALU0, LW1, ALU1, one per cycle.
- Overflow: both sources valid for 4 consecutive cycles with DEPTH=4 → ovf_err=1 at the first drop and stays set. Every broadcast entry is intact and in order, and only ALU entries are missing.
- Mid-drain reset: assert rst while 3 entries are queued → cdb_valid=0 immediately (asynchronous), and after release nothing stale is broadcast.

Source files
------------

// File: rtl/cdb_pkg.sv
// Shared types and widths for the CDB writeback arbiter.
package cdb_pkg;

  localparam int unsigned REG_W         = 5;
  localparam int unsigned TAG_W         = 5;
  localparam int unsigned DATA_W        = 32;
  localparam int unsigned DEPTH_DEFAULT = 4;

  // One completed result as queued and broadcast on the CDB.
  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } cdb_entry_t;

endpackage

// File: rtl/cdb_fifo.sv
// Two-write / one-read result FIFO. wr1 is only meaningful together with wr0
// and lands in the slot after wr0. Storage is deliberately not reset.
module cdb_fifo
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr0_i,
  input  cdb_entry_t               wr0_data_i,
  input  logic                     wr1_i,
  input  cdb_entry_t               wr1_data_i,
  input  logic                     pop_i,
  output cdb_entry_t               head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   free_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  cdb_entry_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, wr_ptr_nx;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Next pointer/count state; pointers wrap naturally on a power-of-two depth.
  always_comb begin
    wr_ptr_nx = wr_ptr_q + PTR_W'(1);
    wr_ptr_d  = wr_ptr_q + PTR_W'(wr0_i) + PTR_W'(wr1_i);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop_i);
    count_d   = count_q + CNT_W'(wr0_i) + CNT_W'(wr1_i) - CNT_W'(pop_i);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage: wr0 at the write pointer, wr1 right behind it.
  always_ff @(posedge clk) begin
    if (wr0_i) mem_q[wr_ptr_q]  <= wr0_data_i;
    if (wr1_i) mem_q[wr_ptr_nx] <= wr1_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  // Slots available to this cycle's pushes once the same-cycle pop is counted.
  assign free_o  = CNT_W'(DEPTH) - count_q + CNT_W'(pop_i);

endmodule

// File: rtl/cdb_writeback_arb.sv
// Writeback arbiter: queues ALU and load results and broadcasts one per cycle
// on the CDB. Optional same-cycle bypass on an empty queue: CDB_BYPASS_EN.
module cdb_writeback_arb
  import cdb_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_ALU,
  input  logic [REG_W-1:0]  dst_ALU,
  input  logic [TAG_W-1:0]  tag_ALU,
  input  logic [DATA_W-1:0] data_ALU,
  input  logic              we_LW,
  input  logic [REG_W-1:0]  dst_LW,
  input  logic [TAG_W-1:0]  tag_LW,
  input  logic [DATA_W-1:0] data_LW,
  output logic              cdb_valid,
  output logic [REG_W-1:0]  cdb_dst,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              almost_full,
  output logic              ovf_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  cdb_entry_t       lw_entry, alu_entry, head, wr0_data, cdb_entry;
  logic [CNT_W-1:0] count, free;
  logic             nonempty, pop;
  logic             byp_lw, byp_alu;
  logic             lw_req, alu_req, lw_acc, alu_acc;
  logic             wr0, wr1;
  logic             ovf_q, ovf_d;

  assign lw_entry  = {dst_LW, tag_LW, data_LW};
  assign alu_entry = {dst_ALU, tag_ALU, data_ALU};
  assign nonempty  = (count != '0);
  // No CDB backpressure: the head leaves every cycle the queue holds something.
  assign pop       = nonempty;

`ifdef CDB_BYPASS_EN
  // On an empty queue one result goes straight to the CDB; loads win if both.
  assign byp_lw  = ~nonempty & we_LW;
  assign byp_alu = ~nonempty & we_ALU & ~we_LW;
`else
  assign byp_lw  = 1'b0;
  assign byp_alu = 1'b0;
`endif

  // Admission: loads are older so they take the first slot; ALU drops first.
  always_comb begin
    lw_req   = we_LW & ~byp_lw;
    alu_req  = we_ALU & ~byp_alu;
    lw_acc   = lw_req & (free != '0);
    alu_acc  = alu_req & (free > CNT_W'(lw_acc));
    wr0      = lw_acc | alu_acc;
    wr1      = lw_acc & alu_acc;
    wr0_data = lw_acc ? lw_entry : alu_entry;
    ovf_d    = ovf_q | (lw_req & ~lw_acc) | (alu_req & ~alu_acc);
  end

  cdb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst),
    .wr0_i      (wr0),
    .wr0_data_i (wr0_data),
    .wr1_i      (wr1),
    .wr1_data_i (alu_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (count),
    .free_o     (free)
  );

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_q <= 1'b0;
    else      ovf_q <= ovf_d;
  end

  // CDB source select; everything reads zero when nothing is broadcast.
  always_comb begin
    cdb_valid = 1'b0;
    cdb_entry = '0;
    if (byp_lw) begin
      cdb_valid = 1'b1;
      cdb_entry = lw_entry;
    end else if (byp_alu) begin
      cdb_valid = 1'b1;
      cdb_entry = alu_entry;
    end else if (nonempty) begin
      cdb_valid = 1'b1;
      cdb_entry = head;
    end
  end

  assign cdb_dst     = cdb_entry.dst;
  assign cdb_tag     = cdb_entry.tag;
  assign cdb_data    = cdb_entry.data;
  // Threshold leaves room for one more dual push.
  assign almost_full = (count >= CNT_W'(DEPTH - 2));
  assign ovf_err     = ovf_q;

endmodule
